// File: rtl/axi_master_arbiter.sv
// -----------------------------------------------------------------------------
// axi_master_arbiter
//   Schedules ownership of one shared external AXI port among NUM_MASTERS
//   cache-controller requesters (index 0 = instruction fetch, index 1 = data
//   access by default). Only one transaction is in flight at a time. The block
//   tracks it from the address handshake to its final response, rotates
//   priority round-robin, and force-releases the bus if the response never
//   arrives within TIMEOUT_CYCLES.
//
// Ports
//   i_aclk      : system clock, rising edge.
//   i_areset_n  : asynchronous active-low reset.
//   i_req       : per-master request, held until granted or abandoned.
//   i_wr        : per-master transaction type (1 = write, 0 = read).
//   i_addr_hs   : shared-bus address handshake (AR or AW channel).
//   i_rlast_hs  : shared-bus final read beat accepted.
//   i_b_hs      : shared-bus write response accepted.
//   o_grant     : one-hot owner select, zero when there is no owner.
//   o_grant_id  : binary owner index, keeps the last owner while idle.
//   o_write     : type of the current transaction.
//   o_busy      : a transaction is granted or outstanding.
//   o_timeout   : single-cycle pulse when the response watchdog expires.
// -----------------------------------------------------------------------------
module axi_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_aclk,
  input  logic                           i_areset_n,
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [NUM_MASTERS-1:0]         i_wr,
  input  logic                           i_addr_hs,
  input  logic                           i_rlast_hs,
  input  logic                           i_b_hs,
  output logic [NUM_MASTERS-1:0]         o_grant,
  output logic [$clog2(NUM_MASTERS)-1:0] o_grant_id,
  output logic                           o_write,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int IDW = $clog2(NUM_MASTERS);
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Counter value on the last cycle the owner is allowed to wait.
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    GRANT_ADDR = 2'b01,
    WAIT_RESP  = 2'b10
  } state_t;

  state_t                 state_r;
  logic [IDW-1:0]         ptr_r;
  logic [CW-1:0]          cnt_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [IDW-1:0]         grant_id_r;
  logic                   write_r;
  logic                   busy_r;
  logic                   timeout_r;

  logic [IDW-1:0]         sel_s;
  logic                   found_s;
  logic [IDW-1:0]         idx_s;
  logic [NUM_MASTERS-1:0] onehot_s;
  logic                   done_s;
  logic                   expire_s;

  // Round-robin pick: first requester after the pointer, wrapping around.
  always_comb begin
    sel_s   = ptr_r;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx_s = IDW'((int'(ptr_r) + i) % NUM_MASTERS);
      if (!found_s && i_req[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    onehot_s        = {NUM_MASTERS{1'b0}};
    onehot_s[sel_s] = 1'b1;
  end

  // Completion uses only the strobe that matches the latched type; the
  // watchdog fires on the last allowed wait cycle if enabled.
  always_comb begin
    if (write_r) begin
      done_s = i_b_hs;
    end else begin
      done_s = i_rlast_hs;
    end
    if (WD_EN && (cnt_r == TO_LAST)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_r    <= IDLE;
      ptr_r      <= IDW'(NUM_MASTERS - 1);
      cnt_r      <= {CW{1'b0}};
      grant_r    <= {NUM_MASTERS{1'b0}};
      grant_id_r <= {IDW{1'b0}};
      write_r    <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r    <= GRANT_ADDR;
            grant_r    <= onehot_s;
            grant_id_r <= sel_s;
            write_r    <= i_wr[sel_s];
            busy_r     <= 1'b1;
          end
        end
        GRANT_ADDR: begin
          // Address handshake wins over a same-cycle request drop.
          if (i_addr_hs) begin
            state_r <= WAIT_RESP;
            ptr_r   <= grant_id_r;
            cnt_r   <= {CW{1'b0}};
          end else if (!i_req[grant_id_r]) begin
            // Abandoned before the address went out: pointer stays put so
            // the same master keeps its turn.
            state_r <= IDLE;
            grant_r <= {NUM_MASTERS{1'b0}};
            busy_r  <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (done_s) begin
            state_r <= IDLE;
            grant_r <= {NUM_MASTERS{1'b0}};
            busy_r  <= 1'b0;
          end else if (expire_s) begin
            state_r   <= IDLE;
            grant_r   <= {NUM_MASTERS{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {NUM_MASTERS{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant    = grant_r;
  assign o_grant_id = grant_id_r;
  assign o_write    = write_r;
  assign o_busy     = busy_r;
  assign o_timeout  = timeout_r;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_master_arbiter
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared with a transaction-level model that tracks the
//   current owner, whether its address has gone out, and how long it has been
//   waiting for a response.
// -----------------------------------------------------------------------------
module tb_axi_master_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] wr;
  logic         addr_hs;
  logic         rlast_hs;
  logic         b_hs;
  logic [N-1:0] grant;
  logic [0:0]   grant_id;
  logic         write;
  logic         busy;
  logic         timeout;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  int m_owner;     // -1 when nobody owns the bus
  int m_last;      // last master that got its address out
  int m_id;
  int m_waited;
  bit m_addr_done;
  bit m_write;
  bit m_timeout;

  axi_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_aclk     (clk),
    .i_areset_n (rst_n),
    .i_req      (req),
    .i_wr       (wr),
    .i_addr_hs  (addr_hs),
    .i_rlast_hs (rlast_hs),
    .i_b_hs     (b_hs),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_write    (write),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_id = 0; m_waited = 0;
    m_addr_done = 1'b0; m_write = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step();
    bit done;
    int cand;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (m_owner < 0 && req[cand]) begin
          m_owner = cand; m_id = cand; m_write = wr[cand]; m_addr_done = 1'b0;
        end
      end
    end else if (!m_addr_done) begin
      if (addr_hs) begin
        m_addr_done = 1'b1; m_last = m_owner; m_waited = 0;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end
    end else begin
      done = m_write ? b_hs : rlast_hs;
      if (done) m_owner = -1;
      else if (m_waited == TO - 1) begin
        m_owner = -1; m_timeout = 1'b1;
      end else m_waited++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, "_grant"},   32'(grant),    32'(eg));
    chk({tag, "_id"},      32'(grant_id), 32'(m_id));
    chk({tag, "_write"},   32'(write),    32'(m_write));
    chk({tag, "_busy"},    32'(busy),     32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(timeout),  32'(m_timeout));
  endtask

  // One clock: inputs already driven; advance model at the edge, compare at negedge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] w,
                     input logic a, input logic rl, input logic b, input string tag);
    req = r; wr = w; addr_hs = a; rlast_hs = rl; b_hs = b;
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [N-1:0] seen [4];
    int got;
    logic [N-1:0] rr, rw;
    logic ra, rrl, rb;

    rst_n = 1'b0; req = 2'b11; wr = 2'b00; addr_hs = 1'b0; rlast_hs = 1'b0; b_hs = 1'b0;
    model_reset();
    repeat (3) cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "rst");
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);

    // Release reset: master 0 first, then master 1 after a read completes.
    rst_n = 1'b1;
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "rel");
    chk("first_grant", 32'(grant), 32'h1);
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "rel_addr");
    repeat (4) cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "rel_wait");
    chk("rel_hold", 32'(grant), 32'h1);
    cyc(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, "rel_done");
    chk("rel_drop", 32'(grant), 32'h0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "rel_next");
    chk("second_grant", 32'(grant), 32'h2);
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "m1_addr");
    cyc(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, "m1_done");

    // Master 1 write: the read strobe must not end it.
    cyc(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, "wr_gnt");
    chk("wr_write", 32'(write), 32'h1);
    cyc(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, "wr_addr");
    cyc(2'b10, 2'b10, 1'b0, 1'b1, 1'b0, "wr_rlast");
    chk("wr_ignore_rlast", 32'(grant), 32'h2);
    repeat (2) cyc(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, "wr_wait");
    chk("wr_hold_write", 32'(write), 32'h1);
    cyc(2'b00, 2'b10, 1'b0, 1'b0, 1'b1, "wr_b");
    chk("wr_release", 32'(grant), 32'h0);

    // Abandon keeps the pointer: master 0 wins again.
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "ab_gnt");
    chk("ab_grant0", 32'(grant), 32'h1);
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "ab_drop");
    chk("ab_idle", 32'(busy), 32'h0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "ab_regnt");
    chk("ab_regrant0", 32'(grant), 32'h1);

    // Alternation with continuous requests.
    for (int k = 0; k < 4; k++) begin
      seen[k] = grant;
      cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "alt_addr");
      cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "alt_wait");
      cyc(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, "alt_done");
      chk("alt_gap", 32'(grant), 32'h0);
      cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "alt_next");
    end
    chk("alt0", 32'(seen[0]), 32'h1);
    chk("alt1", 32'(seen[1]), 32'h2);
    chk("alt2", 32'(seen[2]), 32'h1);
    chk("alt3", 32'(seen[3]), 32'h2);

    // Watchdog: master 0 read with no response.
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "to_addr");
    got = -1;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "to_wait");
      if (timeout) got = n;
    end
    chk("to_latency", 32'(got), 32'd16);
    chk("to_grant", 32'(grant), 32'h0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "to_next");
    chk("to_pulse_once", 32'(timeout), 32'h0);
    chk("to_next_grant", 32'(grant), 32'h2);

    // Async reset during WAIT_RESP.
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "ar_addr");
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "ar_wait");
    #1 rst_n = 1'b0;
    #1;
    chk("ar_grant",  32'(grant),    32'h0);
    chk("ar_busy",   32'(busy),     32'h0);
    chk("ar_id",     32'(grant_id), 32'h0);
    chk("ar_write",  32'(write),    32'h0);
    model_reset();
    repeat (2) cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "ar_hold");
    rst_n = 1'b1;
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "ar_rel");
    chk("ar_first_grant", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      rr  = (($urandom_range(0, 9)) == 0) ? N'($urandom) : (req | N'($urandom_range(0, 3)));
      rw  = N'($urandom);
      ra  = ($urandom_range(0, 3) == 0);
      rrl = !ra && ($urandom_range(0, 19) == 0);
      rb  = !ra && ($urandom_range(0, 19) == 0);
      cyc(rr, rw, ra, rrl, rb, "rnd");
      if (busy === 1'b0 && $urandom_range(0, 3) == 0) req = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Grants exclusive ownership of one shared external AXI port to NUM_MASTERS cache-controller masters. Default requesters: instruction fetch (index 0) and data memory access (index 1).
- Scheduler only: produces one-hot grant/select for the shared-bus mux and tracks each transaction from address handshake to final response.
- One transaction in flight at a time; round-robin fairness; response watchdog.

Parameters:
- NUM_MASTERS, 2, number of requesters (>=2).
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_RESP before forced release; 0 disables the watchdog.

Ports:
- i_aclk  input  1  system clock; all state updates on rising edge.
- i_areset_n  input  1  asynchronous active-low reset.
- i_req  input  NUM_MASTERS  per-master request; held high until grant (or abandoned).
- i_wr  input  NUM_MASTERS  per-master type: 1=write, 0=read; valid while i_req is high.
- i_addr_hs  input  1  shared-bus address handshake (ARVALID&ARREADY or AWVALID&AWREADY).
- i_rlast_hs  input  1  shared-bus RVALID&RREADY&RLAST.
- i_b_hs  input  1  shared-bus BVALID&BREADY.
- o_grant  output  NUM_MASTERS  one-hot owner select; all-zero when no owner.
- o_grant_id  output  $clog2(NUM_MASTERS)  binary index of owner; holds last owner when idle.
- o_write  output  1  latched type of current transaction.
- o_busy  output  1  high in GRANT_ADDR or WAIT_RESP.
- o_timeout  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_grant=0; o_grant_id=0; o_write=0; o_busy=0; o_timeout=0; rr pointer=NUM_MASTERS-1, so master 0 wins first; watchdog counter=0.
- All outputs are registered.
- IDLE:
  - if any i_req bit is set, select the first requesting index searching from pointer+1 with wrap-around.
  - Next cycle: o_grant/o_grant_id set, o_write=i_wr[sel], state=GRANT_ADDR.
  - Grant latency is 1 cycle after i_req is sampled high.
- GRANT_ADDR:
  - i_addr_hs=1 -> WAIT_RESP; pointer=owner; counter cleared.
  - i_req[owner]=0 without i_addr_hs -> abandon: IDLE, o_grant=0, pointer unchanged.
  - i_addr_hs takes priority over a simultaneous req drop.
- WAIT_RESP:
  - Read completes on i_rlast_hs; write completes on i_b_hs. Completion -> IDLE, o_grant=0 next cycle.
  - The non-matching completion strobe is ignored. i_req changes are ignored.
  - Counter increments each cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no completion -> IDLE, o_timeout=1 for exactly one cycle; pointer keeps the owner.
  - Completion in the same cycle as expiry: counts as normal completion, no timeout pulse.
- Completion strobes seen in IDLE or GRANT_ADDR are ignored. Same-cycle i_addr_hs and completion cannot occur per AXI ordering; if they do, only i_addr_hs is acted on.
- Minimum back-to-back spacing: completion cycle -> IDLE cycle -> next grant. There is at least one idle cycle between owners, by design, so the mux never switches mid-beat.
- o_grant is never multi-hot. o_busy = (state != IDLE).
- Reset asserted mid-transaction: immediate return to reset values. The external bus is reset by the same i_areset_n.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Reset: hold i_areset_n=0 with i_req=2'b11 -> o_grant=0, o_busy=0. After release: cycle 1 o_grant=2'b01; i_addr_hs, then i_rlast_hs 5 cycles later -> grant drops; 2 cycles later o_grant=2'b10.
- Continuous i_req=2'b11, each transaction addr_hs plus completion -> grants alternate 01,10,01,10 over 4 transactions. Never 2'b11; at least one all-zero cycle between grants.
- Master 1 write (i_wr=2'b10): i_addr_hs, then i_rlast_hs pulse (ignored), then i_b_hs 3 cycles later -> o_write=1 throughout; release only after i_b_hs.
- Master 0 granted, i_req[0] drops before i_addr_hs -> IDLE next cycle. With i_req=2'b11 next, master 0 granted again (pointer unchanged).
- TIMEOUT_CYCLES=16: read with i_addr_hs, no i_rlast_hs -> o_timeout pulses exactly once, 16 cycles after WAIT_RESP entry; o_grant=0; next requester served.
- i_areset_n pulsed low during WAIT_RESP -> outputs return to reset values asynchronously. First grant after release goes to master 0.
